// File: rtl/breath_pwm_pkg.sv
// Shared constants for the breathing PWM block: mode codes,
// the raised-cosine shape table and the triangle shape helper.
package breath_pwm_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_SINE  = 2'b01,
    MODE_TRI   = 2'b10,
    MODE_CONST = 2'b11
  } mode_e;

  // round(127.5 * (1 - cos(2*pi*i/64)))
  localparam logic [7:0] SINE_LUT [64] = '{
    8'd0,   8'd1,   8'd2,   8'd5,
    8'd10,  8'd15,  8'd21,  8'd29,
    8'd37,  8'd47,  8'd57,  8'd67,
    8'd79,  8'd90,  8'd103, 8'd115,
    8'd128, 8'd140, 8'd152, 8'd165,
    8'd176, 8'd188, 8'd198, 8'd208,
    8'd218, 8'd226, 8'd234, 8'd240,
    8'd245, 8'd250, 8'd253, 8'd254,
    8'd255, 8'd254, 8'd253, 8'd250,
    8'd245, 8'd240, 8'd234, 8'd226,
    8'd218, 8'd208, 8'd198, 8'd188,
    8'd176, 8'd165, 8'd152, 8'd140,
    8'd128, 8'd115, 8'd103, 8'd90,
    8'd79,  8'd67,  8'd57,  8'd47,
    8'd37,  8'd29,  8'd21,  8'd15,
    8'd10,  8'd5,   8'd2,   8'd1
  };

  // Rising ramp for i < 32, mirrored falling ramp above;
  // low bits replicate the top bits so 31/32 reach 255.
  function automatic logic [7:0] tri_val(input logic [5:0] i);
    logic [4:0] t;
    t = i[5] ? ~i[4:0] : i[4:0];
    return {t, t[4:2]};
  endfunction

endpackage

// File: rtl/breath_pwm_if.sv
// Control/status bundle of the breathing PWM block.
// master drives enable/mode/level/prescale/phase_step; slave drives pulse/frame_start/index.
interface breath_pwm_if #(
  parameter int PWM_BITS   = 6,
  parameter int CHANNELS   = 3,
  parameter int PRESC_BITS = 8
);

  logic                  enable;
  logic [1:0]            mode;
  logic [PWM_BITS-1:0]   level;
  logic [PRESC_BITS-1:0] prescale;
  logic [5:0]            phase_step;
  logic [CHANNELS-1:0]   pulse;
  logic                  frame_start;
  logic [5:0]            index;

  modport master (
    output enable, mode, level,
    output prescale, phase_step,
    input  pulse, frame_start, index
  );

  modport slave (
    input  enable, mode, level,
    input  prescale, phase_step,
    output pulse, frame_start, index
  );

endinterface

// File: rtl/breath_pwm_shaper.sv
// Combinational shape lookup: idx/mode/level -> duty.
// Ports: idx (6b), mode (2b), level (PWM_BITS) in; duty (PWM_BITS) out.
module breath_pwm_shaper
  import breath_pwm_pkg::*;
#(
  parameter int PWM_BITS = 6
) (
  input  logic [5:0]          idx,
  input  logic [1:0]          mode,
  input  logic [PWM_BITS-1:0] level,
  output logic [PWM_BITS-1:0] duty
);

  logic [7:0] v;

  always_comb begin
    v = '0;
    unique case (1'b1)
      (mode == MODE_SINE): v = SINE_LUT[idx];
      (mode == MODE_TRI):  v = tri_val(idx);
      default:             v = '0;
    endcase
    duty = (mode == MODE_CONST) ? level
                                : v[7 -: PWM_BITS];
  end

endmodule

// File: rtl/breath_pwm_multi.sv
// Multi-channel breathing PWM: shared frame counter, prescaled index, per-channel phase.
// Ports: sysclk, rst_n (async low), bus (breath_pwm_if.slave).
module breath_pwm_multi
  import breath_pwm_pkg::*;
#(
  parameter int PWM_BITS   = 6,
  parameter int CHANNELS   = 3,
  parameter int PRESC_BITS = 8
) (
  input  logic      sysclk,
  input  logic      rst_n,
  breath_pwm_if.slave bus
);

  logic [PWM_BITS-1:0]   cnt_q, cnt_d;
  logic [PRESC_BITS-1:0] frame_cnt_q, frame_cnt_d;
  logic [5:0]            index_q, index_d;
  logic [PWM_BITS-1:0]   duty_q [CHANNELS];
  logic [PWM_BITS-1:0]   duty_d [CHANNELS];
  logic [PWM_BITS-1:0]   shape  [CHANNELS];
  logic [CHANNELS-1:0]   pulse_q, pulse_d;
  logic                  fs_q, fs_d;
  logic                  frame_end;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic [5:0] ch_idx;
    assign ch_idx = index_q + bus.phase_step * 6'(k);
    breath_pwm_shaper #(
      .PWM_BITS(PWM_BITS)
    ) u_shaper (
      .idx  (ch_idx),
      .mode (bus.mode),
      .level(bus.level),
      .duty (shape[k])
    );
  end

  always_comb begin
    frame_end   = &cnt_q;
    cnt_d       = cnt_q;
    frame_cnt_d = frame_cnt_q;
    index_d     = index_q;
    duty_d      = duty_q;
    fs_d        = bus.enable && (cnt_q == '0);
    pulse_d     = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      pulse_d[k] = bus.enable && (cnt_q < duty_q[k]);
    end
    if (!bus.enable) begin
      cnt_d       = '0;
      frame_cnt_d = '0;
      index_d     = '0;
      for (int k = 0; k < CHANNELS; k++) begin
        duty_d[k] = '0;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
      if (frame_end) begin
        // >= so a prescale lowered under frame_cnt steps now
        if (frame_cnt_q >= bus.prescale) begin
          frame_cnt_d = '0;
          index_d     = index_q + 1'b1;
        end else begin
          frame_cnt_d = frame_cnt_q + 1'b1;
        end
        // shape uses the pre-increment index
        duty_d = shape;
      end
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      frame_cnt_q <= '0;
      index_q     <= '0;
      pulse_q     <= '0;
      fs_q        <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
        duty_q[k] <= '0;
      end
    end else begin
      cnt_q       <= cnt_d;
      frame_cnt_q <= frame_cnt_d;
      index_q     <= index_d;
      pulse_q     <= pulse_d;
      fs_q        <= fs_d;
      for (int k = 0; k < CHANNELS; k++) begin
        duty_q[k] <= duty_d[k];
      end
    end
  end

  assign bus.pulse       = pulse_q;
  assign bus.frame_start = fs_q;
  assign bus.index       = index_q;

endmodule

// File: doc/breath_pwm_multi.md
Name: breath_pwm_multi

Overview:
Multi-channel "breathing" PWM generator for LED/indicator outputs.
- One shared free-running PWM frame counter drives all channels.
- A waveform index advances once every (prescale+1) PWM frames and walks a 64-point shape.
- Each channel reads the shape at its own phase offset, so several LEDs can breathe in a staggered pattern.
- Mode selects sine (raised-cosine) breathing, triangle breathing, constant level, or off. Sits between the switch/control logic and the LED pins.

Parameters:
PWM_BITS, 6, PWM counter/duty width (1..8); frame = 2^PWM_BITS cycles
CHANNELS, 3, number of pulse outputs (1..16)
PRESC_BITS, 8, width of prescale input

Ports:
sysclk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
enable  in  1  global run enable
mode  in  2  00 off, 01 sine, 10 triangle, 11 constant
level  in  PWM_BITS  duty used in constant mode
prescale  in  PRESC_BITS  index advances every prescale+1 frames
phase_step  in  6  channel k index offset = k*phase_step (mod 64)
pulse  out  CHANNELS  registered PWM outputs
frame_start  out  1  one-cycle strobe, first cycle of each frame
index  out  6  current shared waveform index

Behaviour:
- Reset (rst_n low, asynchronous): cnt, frame_cnt, index, all duty_q, pulse, frame_start = 0. No output toggles until enable is high after release.
- cnt (PWM_BITS) increments each cycle while enable = 1 and wraps all-ones to 0. Frame end is the cycle with cnt == all-ones.
- At frame end:
  - if frame_cnt >= prescale: frame_cnt <= 0 and index <= index + 1 (wraps 63 to 0).
  - else: frame_cnt <= frame_cnt + 1.
  - Using >= means a prescale reduced below the current frame_cnt steps at the next frame end. It never hangs.
- Duty latching, per channel k:
  - At frame end, duty_q[k] latches shape(mode, (index + k*phase_step) mod 64, level).
  - The index value used is the one before that edge's increment, so an index change reaches the outputs one frame later.
  - mode, level and phase_step changes mid-frame never glitch the current frame.
- Shape, as an 8-bit value v, duty = v >> (8 - PWM_BITS):
  - sine: v = SINE_LUT[i], where SINE_LUT[i] = round(127.5*(1 - cos(2*pi*i/64))); [0] = 0, [32] = 255.
  - triangle: t = i[5] ? ~i[4:0] : i[4:0]; v = {t, t[4:2]}.
  - constant: duty = level directly.
  - off: duty = 0.
- Output registers:
  - pulse[k] <= enable & (cnt < duty_q[k]), so pulse is one cycle behind cnt. Duty 0 means never high; duty all-ones means high 2^N - 1 of 2^N cycles (no 100%).
  - frame_start <= enable & (cnt == 0).
- enable low:
  - cnt, frame_cnt, index and duty_q are synchronously cleared.
  - pulse and frame_start go 0 on the next edge.
  - On re-enable the sequence restarts from index 0. The first frame has duty 0 because duty_q is loaded only at frame end.
- Reset mid-frame: outputs clear immediately; no partial pulse is completed.

Decomposition:
- Package breath_pwm_pkg holds:
  - the 64 x 8-bit SINE_LUT constant
  - mode encodings MODE_OFF/SINE/TRI/CONST
  - a triangle-value function
- Sub-module breath_pwm_shaper (combinational: index, mode, level -> duty, parameterised by PWM_BITS) is instantiated CHANNELS times inside a generate loop.
- Counters, prescaler and output registers live in the top.

Test Plan:
- Reset: assert rst_n low at cnt = 20 while pulses are active -> pulse = 0, frame_start = 0, index = 0 immediately; nothing toggles until enable is high after release.
- Constant mode: mode = 11, prescale = 0, level = 16 -> each channel high exactly 16 of every 64 cycles, starting from frame 2 (frame 1 has duty 0). level = 0 -> never high; level = 63 -> high 63/64.
- Triangle walk: mode = 10, prescale = 0, phase_step = 0 -> index increments every 64 cycles. Duty is 0 at index 0, 63 at index 31 and 32, and 2 at index 1 ({00001,000} = 8 >> 2). Each index's duty appears on pulse one frame after index changes.
- Phase spread: mode = 10, phase_step = 16, index = 0 -> channels 0/1/2 latch duty 0/33/63; sine mode at the same point -> 0/32/63.
- Prescale: prescale = 3 -> index steps every 256 cycles. Change prescale 10 to 2 while frame_cnt = 5 -> step at the very next frame end, then every 3 frames.
- Enable drop: deassert enable mid-frame at index 17 -> pulse = 0 next cycle and index = 0. Reassert -> frame_start pulses 1 cycle after enable rises, then every 64 cycles.
